// File: rtl/regfile_mp.sv
// Multi-port general-purpose register file with optional zero register,
// write-to-read bypass and a per-register busy scoreboard.
module regfile_mp #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] RA,
    output logic [NUM_RD*DATA_WIDTH-1:0] RD,
    output logic [NUM_RD-1:0]            RBUSY,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] WA,
    input  logic [NUM_WR*DATA_WIDTH-1:0] WD,
    input  logic [NUM_WR-1:0]            WE,
    input  logic [ADDR_WIDTH-1:0]        BA,
    input  logic                         BSET
);

    localparam int DEPTH     = 32'sd1 << ADDR_WIDTH;
    localparam bit ZERO_EN   = (ZERO_REG != 32'sd0);
    localparam bit BYPASS_EN = (BYPASS != 32'sd0);

    if ((NUM_RD < 32'sd1) || (NUM_RD > 32'sd8)) begin : g_bad_num_rd
        $error("regfile_mp: NUM_RD must be in 1..8");
    end
    if ((NUM_WR < 32'sd1) || (NUM_WR > 32'sd4)) begin : g_bad_num_wr
        $error("regfile_mp: NUM_WR must be in 1..4");
    end

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0]      busy_r;
    logic                  run_r;
    logic [ADDR_WIDTH-1:0] ra_s;
    logic                  hit_s;
    logic [DATA_WIDTH-1:0] byp_s;

    // run_r holds off the edge that samples reset release so coincident writes are dropped
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            run_r <= 1'b0;
        end else begin
            run_r <= 1'b1;
        end
    end

    // Storage update: later ports overwrite earlier ones, so the highest index wins
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_r[k] <= '0;
            end
        end else if (run_r) begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (WE[j] && !(ZERO_EN && (WA[j*ADDR_WIDTH +: ADDR_WIDTH] == '0))) begin
                    mem_r[WA[j*ADDR_WIDTH +: ADDR_WIDTH]] <= WD[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Scoreboard: retiring writes clear, a new issue sets afterwards so set wins on conflict
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            busy_r <= '0;
        end else if (run_r) begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (WE[j]) begin
                    busy_r[WA[j*ADDR_WIDTH +: ADDR_WIDTH]] <= 1'b0;
                end
            end
            if (BSET && !(ZERO_EN && (BA == '0))) begin
                busy_r[BA] <= 1'b1;
            end
        end
    end

    // Read ports: zero register first, then highest-index bypass hit, then storage
    always_comb begin
        RD    = '0;
        RBUSY = '0;
        ra_s  = '0;
        hit_s = 1'b0;
        byp_s = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra_s  = RA[i*ADDR_WIDTH +: ADDR_WIDTH];
            hit_s = 1'b0;
            byp_s = '0;
            for (int j = 0; j < NUM_WR; j++) begin
                if (BYPASS_EN && WE[j] && (WA[j*ADDR_WIDTH +: ADDR_WIDTH] == ra_s)) begin
                    hit_s = 1'b1;
                    byp_s = WD[j*DATA_WIDTH +: DATA_WIDTH];
                end else begin
                    hit_s = hit_s;
                    byp_s = byp_s;
                end
            end
            if (ZERO_EN && (ra_s == '0)) begin
                RD[i*DATA_WIDTH +: DATA_WIDTH] = '0;
                RBUSY[i] = 1'b0;
            end else if (hit_s) begin
                RD[i*DATA_WIDTH +: DATA_WIDTH] = byp_s;
                RBUSY[i] = 1'b0;
            end else begin
                RD[i*DATA_WIDTH +: DATA_WIDTH] = mem_r[ra_s];
                RBUSY[i] = busy_r[ra_s];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: a 3-read/2-write bypassing file and a 1-read/1-write
// non-bypassing file share clock and reset.
module tb_regfile_mp;

    logic        CLK;
    logic        RST_N;

    logic [14:0] ra_a;
    logic [95:0] rd_a;
    logic [2:0]  rbusy_a;
    logic [9:0]  wa_a;
    logic [63:0] wd_a;
    logic [1:0]  we_a;
    logic [4:0]  ba_a;
    logic        bset_a;

    logic [4:0]  ra_b;
    logic [31:0] rd_b;
    logic [0:0]  rbusy_b;
    logic [4:0]  wa_b;
    logic [31:0] wd_b;
    logic [0:0]  we_b;
    logic [4:0]  ba_b;
    logic        bset_b;

    int checks_r;
    int errors_r;

    regfile_mp #(
        .ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(3), .NUM_WR(2),
        .ZERO_REG(1), .BYPASS(1)
    ) u_dut (
        .CLK(CLK), .RST_N(RST_N), .RA(ra_a), .RD(rd_a), .RBUSY(rbusy_a),
        .WA(wa_a), .WD(wd_a), .WE(we_a), .BA(ba_a), .BSET(bset_a)
    );

    regfile_mp #(
        .ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(1), .NUM_WR(1),
        .ZERO_REG(1), .BYPASS(0)
    ) u_nobyp (
        .CLK(CLK), .RST_N(RST_N), .RA(ra_b), .RD(rd_b), .RBUSY(rbusy_b),
        .WA(wa_b), .WD(wd_b), .WE(we_b), .BA(ba_b), .BSET(bset_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r++;
        if (got !== exp) begin
            errors_r++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr_a(input int port, input logic [4:0] addr, input logic [31:0] data);
        we_a[port]           = 1'b1;
        wa_a[port*5 +: 5]    = addr;
        wd_a[port*32 +: 32]  = data;
    endtask

    task automatic idle_a();
        we_a   = 2'b00;
        bset_a = 1'b0;
    endtask

    initial begin
        checks_r = 0;
        errors_r = 0;
        RST_N  = 1'b0;
        ra_a = '0; wa_a = '0; wd_a = '0; we_a = '0; ba_a = '0; bset_a = 1'b0;
        ra_b = '0; wa_b = '0; wd_b = '0; we_b = '0; ba_b = '0; bset_b = 1'b0;

        // reset state, and a write pending across the reset-release edge
        ra_a[4:0] = 5'd4;
        ra_b      = 5'd4;
        #2;
        check("rst_rd_a", rd_a[31:0], 32'h0);
        check("rst_rbusy_a", {29'd0, rbusy_a}, 32'h0);
        check("rst_rd_b", rd_b, 32'h0);
        #10;
        wr_a(0, 5'd4, 32'hCAFE0004);
        RST_N = 1'b1;
        tick();
        idle_a();
        #1;
        check("release_edge_ignored", rd_a[31:0], 32'h0);

        // reset mid-operation
        wr_a(0, 5'd5, 32'hDEADBEEF);
        tick();
        idle_a();
        ba_a = 5'd5; bset_a = 1'b1;
        tick();
        idle_a();
        ra_a[4:0] = 5'd5;
        #1;
        check("r5_written", rd_a[31:0], 32'hDEADBEEF);
        check("r5_busy", {31'd0, rbusy_a[0]}, 32'h1);
        RST_N = 1'b0;
        #1;
        check("r5_async_clear", rd_a[31:0], 32'h0);
        check("r5_async_busy", {31'd0, rbusy_a[0]}, 32'h0);
        RST_N = 1'b1;
        tick();
        tick();
        check("r5_after_release", rd_a[31:0], 32'h0);
        check("r5_busy_after_release", {31'd0, rbusy_a[0]}, 32'h0);

        // zero register
        wr_a(0, 5'd0, 32'hFFFFFFFF);
        ba_a = 5'd0; bset_a = 1'b1;
        ra_a[4:0] = 5'd0;
        #1;
        check("zero_same_cycle", rd_a[31:0], 32'h0);
        check("zero_busy_same", {31'd0, rbusy_a[0]}, 32'h0);
        tick();
        idle_a();
        #1;
        check("zero_next_cycle", rd_a[31:0], 32'h0);
        check("zero_busy_next", {31'd0, rbusy_a[0]}, 32'h0);

        // bypass versus no bypass
        wr_a(0, 5'd7, 32'h12345678);
        ra_a[4:0] = 5'd7;
        we_b = 1'b1; wa_b = 5'd7; wd_b = 32'h12345678; ra_b = 5'd7;
        #1;
        check("bypass_before_edge", rd_a[31:0], 32'h12345678);
        check("nobyp_before_edge", rd_b, 32'h0);
        tick();
        idle_a();
        we_b = 1'b0;
        #1;
        check("bypass_after_edge", rd_a[31:0], 32'h12345678);
        check("nobyp_after_edge", rd_b, 32'h12345678);

        // write conflict, highest port wins
        wr_a(0, 5'd3, 32'h11);
        wr_a(1, 5'd3, 32'h22);
        ra_a[9:5] = 5'd3;
        #1;
        check("conflict_bypass", rd_a[63:32], 32'h22);
        tick();
        idle_a();
        #1;
        check("conflict_stored", rd_a[63:32], 32'h22);

        // scoreboard
        ba_a = 5'd9; bset_a = 1'b1;
        ra_a[4:0] = 5'd9;
        #1;
        check("busy_not_yet", {31'd0, rbusy_a[0]}, 32'h0);
        tick();
        idle_a();
        #1;
        check("busy_set", {31'd0, rbusy_a[0]}, 32'h1);
        wr_a(0, 5'd9, 32'h55);
        #1;
        check("busy_bypass_hidden", {31'd0, rbusy_a[0]}, 32'h0);
        check("busy_bypass_data", rd_a[31:0], 32'h55);
        tick();
        idle_a();
        #1;
        check("busy_cleared", {31'd0, rbusy_a[0]}, 32'h0);
        wr_a(0, 5'd9, 32'h0);
        tick();
        idle_a();
        #1;
        check("r9_zeroed", rd_a[31:0], 32'h0);
        wr_a(0, 5'd9, 32'h55);
        ba_a = 5'd9; bset_a = 1'b1;
        tick();
        idle_a();
        #1;
        check("set_wins_data", rd_a[31:0], 32'h55);
        check("set_wins_busy", {31'd0, rbusy_a[0]}, 32'h1);

        // multi-read
        wr_a(0, 5'd1, 32'd1);
        wr_a(1, 5'd2, 32'd2);
        tick();
        idle_a();
        wr_a(0, 5'd31, 32'd31);
        tick();
        idle_a();
        ra_a = {5'd31, 5'd2, 5'd1};
        #1;
        check("multi_rd0", rd_a[31:0], 32'd1);
        check("multi_rd1", rd_a[63:32], 32'd2);
        check("multi_rd2", rd_a[95:64], 32'd31);
        check("multi_busy", {29'd0, rbusy_a}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule
